dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, meaning the requester index favoured first after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports reqN_valid  input  1  request pending, for N = 0 (CPU) and N = 1 (debug/loader).
REQ-005 The block SHALL have ports reqN_we  input  1  1 = write, 0 = read.
REQ-006 The block SHALL have ports reqN_addr  input  32  byte address.
REQ-007 The block SHALL have ports reqN_wdata  input  32  write data, byte-lane aligned.
REQ-008 The block SHALL have ports reqN_be  input  4  byte enables; bit k selects bits [8k+7:8k].
REQ-009 The block SHALL have ports reqN_ready  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have ports reqN_rdata  output  32  read data, valid while reqN_ready = 1.
REQ-011 The block SHALL have port mem_addr  output  32  word address to the data memory.
REQ-012 The block SHALL have port mem_we  output  1  memory write enable.
REQ-013 The block SHALL have port mem_din  output  32  memory write data.
REQ-014 The block SHALL have port mem_dout  input  32  combinational memory read data for mem_addr.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS, MERGE and DONE.
REQ-016 IDLE: when any reqN_valid = 1, the FSM SHALL latch the winner's we/addr/wdata/be and the owner index, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins; the last-grant pointer SHALL update only on grant.
REQ-018 mem_addr SHALL equal {latched_addr[31:2], 2'b00}; address bits [1:0] SHALL be ignored.
REQ-019 ACCESS, read: the block SHALL capture mem_dout into the rdata register and go to DONE.
REQ-020 ACCESS, write with be = 4'b1111: the block SHALL drive mem_we = 1 and mem_din = wdata, then go to DONE.
REQ-021 ACCESS, write with be = 4'b0000: the block SHALL perform no memory write and go to DONE.
REQ-022 ACCESS, partial write: the block SHALL capture mem_dout into the merge register and go to MERGE.
REQ-023 MERGE: the block SHALL drive mem_we = 1 and mem_din byte k = be[k] ? wdata byte k : merge byte k, then go to DONE.
REQ-024 DONE: the block SHALL pulse the owner's reqN_ready for exactly one cycle and go to IDLE; the other requester's ready SHALL stay 0.
REQ-025 reqN_rdata SHALL present the rdata register for reads; its value for writes SHALL be 0.
REQ-026 Latency, counted from the IDLE cycle in which the request is granted: ready SHALL arrive at +2 cycles for reads, full writes and be = 0 writes, and at +3 cycles for partial writes.
REQ-027 Handshake: a requester SHALL hold valid and its payload until ready, and SHALL drop valid the cycle after ready; valid still high in IDLE SHALL count as a new request.
REQ-028 mem_we SHALL be 1 only in ACCESS (full write) or MERGE, so that at most one write occurs per request.
REQ-029 A request arriving while the FSM is busy SHALL wait; the block SHALL drop no request and SHALL never grant two requests at once.

Reset
REQ-030 Reset SHALL force IDLE, clear all latched registers to 0, and set the last-grant pointer so that requester RR_INIT wins the first tie.
REQ-031 During and after reset: mem_we = 0, mem_addr = 0, mem_din = 0, reqN_ready = 0, reqN_rdata = 0.
REQ-032 Reset in ACCESS or MERGE SHALL abort the transaction: no memory write occurs and no ready is issued.

Configuration
REQ-033 With DM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and RR_INIT and the pointer SHALL have no effect.
REQ-034 Without DM_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-017.

Verification
REQ-035 After reset, req0 writes addr 0x10, wdata 0x11223344, be 4'hF -> mem_we = 1 for one cycle with mem_addr 0x10 and mem_din 0x11223344; req0_ready 2 cycles after the grant.
REQ-036 Memory word 0x10 = 0x11223344; req1 writes addr 0x11, wdata 0x0000AB00, be 4'b0010 -> MERGE writes 0x1122AB44; req1_ready at +3 cycles.
REQ-037 Both requesters hold valid reads of 0x10 continuously -> grants alternate 0,1,0,1, each ready returns 0x1122AB44, and no starvation occurs; with DM_ARB_FIXED_PRIO_EN defined, req0 wins every tie.
REQ-038 A write with be = 4'b0000 -> no mem_we pulse and ready still at +2 cycles.
REQ-039 A partial write with reset asserted in MERGE -> no mem_we and no ready; the FSM is in IDLE the cycle after reset and the memory word is unchanged.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, read / full write / read-modify-write byte merge.
// Optional macro DM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (RR_INIT and pointer unused).
module dm_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_be,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

  // Pointer holds the last granted index; reset value makes RR_INIT win the first tie.
  localparam logic LAST_INIT = (RR_INIT == 0) ? 1'b1 : 1'b0;

  state_t      state, state_nxt;
  logic        owner, last, lat_we;
  logic [31:0] lat_addr, lat_wdata, rdata_q, merge_q, merged;
  logic [3:0]  lat_be;
  logic        grant, winner, be_full, be_none;

  assign grant   = req0_valid | req1_valid;
  assign be_full = (lat_be == 4'hF);
  assign be_none = (lat_be == 4'h0);

  always_comb begin
    winner = ~req0_valid;
`ifdef DM_ARB_FIXED_PRIO_EN
    winner = ~req0_valid;
`else
    if (req0_valid && req1_valid) winner = ~last;
`endif
  end

  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = lat_be[k] ? lat_wdata[8*k +: 8] : merge_q[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= LAST_INIT;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata_q   <= '0;
      merge_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant) begin
        owner     <= winner;
        last      <= winner;
        lat_we    <= winner ? req1_we    : req0_we;
        lat_addr  <= winner ? req1_addr  : req0_addr;
        lat_wdata <= winner ? req1_wdata : req0_wdata;
        lat_be    <= winner ? req1_be    : req0_be;
      end
      if (state == ACCESS) begin
        if (!lat_we) rdata_q <= mem_dout;
        if (lat_we && !be_full && !be_none) merge_q <= mem_dout;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = (lat_we && !be_full && !be_none) ? MERGE : DONE;
      MERGE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by reset so an in-flight write or ready is suppressed in the reset cycle itself.
  always_comb begin
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_din    = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_rdata = '0;
    req1_rdata = '0;
    if (!reset) begin
      mem_addr = {lat_addr[31:2], 2'b00};
      case (state)
        ACCESS: if (lat_we && be_full) begin
          mem_we  = 1'b1;
          mem_din = lat_wdata;
        end
        MERGE: begin
          mem_we  = 1'b1;
          mem_din = merged;
        end
        DONE: begin
          if (owner) begin
            req1_ready = 1'b1;
            req1_rdata = lat_we ? 32'h0 : rdata_q;
          end else begin
            req0_ready = 1'b1;
            req0_rdata = lat_we ? 32'h0 : rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: cycle-by-cycle behavioural model plus directed literal checks and random traffic.
module tb_dm_arbiter;
  localparam int RRI = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  v = '0, we = '0, rdy;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic [31:0] rd0, rd1, mem_addr, mem_din, mem_dout;
  logic        mem_we;
  logic [31:0] tb_mem [16];

  always #5 clk = ~clk;

  dm_arbiter #(.RR_INIT(RRI)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_we(we[0]), .req0_addr(addr[0]), .req0_wdata(wdata[0]), .req0_be(be[0]),
    .req0_ready(rdy[0]), .req0_rdata(rd0),
    .req1_valid(v[1]), .req1_we(we[1]), .req1_addr(addr[1]), .req1_wdata(wdata[1]), .req1_be(be[1]),
    .req1_ready(rdy[1]), .req1_rdata(rd1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  assign mem_dout = tb_mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[5:2]] <= mem_din;

  int errors = 0, checks = 0, we_cnt = 0;
  int rlog[$];
  logic [31:0] dlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = b[k] ? nw[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  // Model: transaction in flight is described by age since grant and total length to ready.
  logic [31:0] mm [16];
  bit          act = 0, own = 0, mwe = 0, last = 1;
  int          age = 0, len = 0;
  logic [31:0] maddr = '0, mwd = '0, mrd = '0;
  logic [3:0]  mbe = '0;

  always @(negedge clk) begin : cmp
    logic        e_we;
    logic [31:0] e_din, e_addr, e_rd;
    logic [1:0]  e_rdy;
    bit          partial, w;
    int          idx;
    e_we = 0; e_din = '0; e_addr = '0; e_rd = '0; e_rdy = '0;
    idx = int'(maddr[5:2]);
    partial = mwe && mbe != 4'hF && mbe != 4'h0;
    if (!reset) begin
      e_addr = {maddr[31:2], 2'b00};
      if (act) begin
        if (mwe && mbe == 4'hF && age == 1) begin e_we = 1; e_din = mwd; end
        if (partial && age == 2) begin e_we = 1; e_din = merge(mm[idx], mwd, mbe); end
        if (age == len) begin e_rdy[own] = 1'b1; e_rd = mwe ? 32'h0 : mrd; end
      end
    end
    check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    check("mem_addr", mem_addr, e_addr);
    check("ready", {30'b0, rdy}, {30'b0, e_rdy});
    if (e_we || reset) check("mem_din", mem_din, e_din);
    if (e_rdy[0] || reset) check("rdata0", rd0, e_rd);
    if (e_rdy[1] || reset) check("rdata1", rd1, e_rd);
    if (mem_we) we_cnt++;
    if (rdy[0]) begin rlog.push_back(0); dlog.push_back(rd0); end
    if (rdy[1]) begin rlog.push_back(1); dlog.push_back(rd1); end
    // advance model to next cycle
    if (reset) begin
      act = 0; own = 0; mwe = 0; maddr = '0; mwd = '0; mbe = '0;
      last = (RRI == 0);
    end else if (act) begin
      if (e_we) mm[idx] = e_din;
      if (age == len) act = 0; else age++;
    end else if (v != 2'b00) begin
      if (v == 2'b11) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = ~last;
`endif
      end else w = v[1];
      own = w; last = w; mwe = we[w]; maddr = addr[w]; mwd = wdata[w]; mbe = be[w];
      len = (mwe && mbe != 4'hF && mbe != 4'h0) ? 3 : 2;
      mrd = mm[maddr[5:2]];
      age = 1; act = 1;
    end
  end

  task automatic req(input int n, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int lat);
    @(posedge clk); #1;
    we[n] = w; addr[n] = a; wdata[n] = d; be[n] = b; v[n] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk); lat++;
      if (rdy[n] || lat >= 60) break;
    end
    checks++;
    if (!rdy[n]) begin errors++; $display("FAIL timeout req%0d: got no ready expected ready within 60 cycles", n); end
    @(posedge clk); #1;
    v[n] = 1'b0;
  endtask

  task automatic rand_traffic(input int n);
    int lat, gap;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      req(n, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), lat);
    end
  endtask

  initial begin
    int lat, w0, r0;
    for (int i = 0; i < 16; i++) begin tb_mem[i] = '0; mm[i] = '0; end
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; be[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {30'b0, rdy}, 32'h0);
    check("post_reset_addr", mem_addr, 32'h0);

    w0 = we_cnt;
    req(0, 1, 32'h10, 32'h11223344, 4'hF, lat);
    check("full_wr_latency", lat, 3);
    check("full_wr_mem", tb_mem[4], 32'h11223344);
    check("full_wr_pulses", we_cnt - w0, 1);

    w0 = we_cnt;
    req(1, 1, 32'h11, 32'h0000AB00, 4'b0010, lat);
    check("part_wr_latency", lat, 4);
    check("part_wr_mem", tb_mem[4], 32'h1122AB44);
    check("part_wr_pulses", we_cnt - w0, 1);

    rlog.delete(); dlog.delete();
    fork
      begin int l; req(0, 0, 32'h10, 0, 0, l); req(0, 0, 32'h10, 0, 0, l); end
      begin int l; req(1, 0, 32'h12, 0, 0, l); req(1, 0, 32'h13, 0, 0, l); end
    join
    check("rr_count", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) begin
      check("rr_order", rlog[i], i % 2);
      check("rr_rdata", dlog[i], 32'h1122AB44);
    end

    w0 = we_cnt;
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'h0, lat);
    check("be0_latency", lat, 3);
    check("be0_pulses", we_cnt - w0, 0);
    check("be0_mem", tb_mem[4], 32'h1122AB44);

    w0 = we_cnt; r0 = rlog.size();
    @(posedge clk); #1;
    we[1] = 1; addr[1] = 32'h10; wdata[1] = 32'hFFFFFFFF; be[1] = 4'b0001; v[1] = 1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; v[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pulses", we_cnt - w0, 0);
    check("abort_ready", rlog.size() - r0, 0);
    check("abort_mem", tb_mem[4], 32'h1122AB44);
    req(0, 0, 32'h10, 0, 0, lat);
    check("after_abort_latency", lat, 3);
    check("after_abort_rdata", dlog[dlog.size() - 1], 32'h1122AB44);

    fork
      rand_traffic(0);
      rand_traffic(1);
    join
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
